instr_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of the control unit and datapath. It owns the program counter and issues one-outstanding read requests to instruction memory with a req/rvalid handshake. Returned words are buffered in a small FIFO. It presents the head instruction, its PC and the pre-sliced `op`/`funct3`/`funct7` fields to the decode stage under a valid/ready handshake. Branch/jump redirects flush the buffer and discard any in-flight response.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and buffer entry layout for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Instruction field positions handed to decode
   localparam int unsigned OP_LSB = 0;
   localparam int unsigned OP_W   = 7;
   localparam int unsigned F3_LSB = 12;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned F7_LSB = 25;
   localparam int unsigned F7_W   = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  wdata,
   output fetch_entry_t  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   fetch_entry_t  mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one memory read in flight and buffers returned words for decode.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [OP_W-1:0] op,
   output logic [F3_W-1:0] funct3,
   output logic [F7_W-1:0] funct7
);

   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned CNTW = CW + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            req_q, req_d;
   logic            push_c, pop_c, flush_c, space_c;
   logic [CNTW-1:0] cnt_next_c;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    fifo_wdata, fifo_head;

   assign fifo_wdata = '{pc: fetch_pc_q, instr: imem_rdata};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .pop   (pop_c),
      .flush (flush_c),
      .wdata (fifo_wdata),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
      end
   end

   // Space check uses the buffer occupancy after this cycle's push/pop; no request is outstanding afterwards
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      flush_c    = 1'b0;
      pop_c      = instr_valid & instr_ready;
      push_c     = (state_q == WAIT) & imem_rvalid & ~fifo_full;
      cnt_next_c = {1'b0, fifo_count} + CNTW'(push_c) - CNTW'(pop_c);
      space_c    = (cnt_next_c < CNTW'(DEPTH));

      case (state_q)
         IDLE: if (space_c) state_d = WAIT;
         WAIT: begin
            if (push_c) fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem_rvalid && !space_c) state_d = IDLE;
         end
         DROP: if (imem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Redirect overrides everything; an unanswered request must have its response discarded
      if (redirect) begin
         flush_c    = 1'b1;
         push_c     = 1'b0;
         pop_c      = 1'b0;
         fetch_pc_d = redirect_pc & ~32'h3;
         case (state_q)
            WAIT, DROP: state_d = imem_rvalid ? IDLE : DROP;
            default:    state_d = IDLE;
         endcase
      end

      req_d = (state_d == WAIT);
   end

   assign imem_req    = req_q;
   assign imem_addr   = fetch_pc_q;
   assign instr_valid = ~fifo_empty;
   assign instr       = fifo_empty ? NOP_INSTR : fifo_head.instr;
   assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;
   assign op          = instr[OP_LSB +: OP_W];
   assign funct3      = instr[F3_LSB +: F3_W];
   assign funct7      = instr[F7_LSB +: F7_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenario bench for instr_fetch_unit with a small configurable-latency memory model.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory model: automatic mode answers after lat waiting cycles with addr|0x13, manual mode is bench-driven
   logic        mem_en    = 1'b0;
   int          lat       = 0;
   int          wcnt      = 0;
   logic        man_rv    = 1'b0;
   logic [31:0] man_rdata = 32'h0;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .op          (op),
      .funct3      (funct3),
      .funct7      (funct7)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      imem_rvalid = mem_en ? (imem_req && (wcnt >= lat)) : man_rv;
      imem_rdata  = mem_en ? (imem_addr | 32'h13) : man_rdata;
   end

   always @(posedge clk) begin
      if (imem_req && !imem_rvalid) wcnt <= wcnt + 1;
      else                          wcnt <= 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b1;
      mem_en      = 1'b0;
      man_rv      = 1'b0;
      man_rdata   = 32'h0;
      lat         = 0;
      step();
      step();
   endtask

   task automatic test_reset();
      hold_reset();
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
      n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
      n_checks++; if (instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr got=%h exp=00000013", instr); end
      n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000000", instr_pc); end
      n_checks++; if (op !== 7'h13 || funct3 !== 3'h0 || funct7 !== 7'h0) begin n_fail++; $display("FAIL reset_fields got=%h/%h/%h exp=13/0/00", op, funct3, funct7); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_in [3];
      exp_pc = '{32'h0, 32'h4, 32'h8};
      exp_in = '{32'h13, 32'h17, 32'h1b};
      mem_en = 1'b1;
      instr_ready = 1'b1;
      rst_n = 1'b1;
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got=%0b@%h exp=1@00000000", imem_req, imem_addr); end
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k]) begin n_fail++; $display("FAIL b2b_pc[%0d] got=%0b/%h exp=1/%h", k, instr_valid, instr_pc, exp_pc[k]); end
         n_checks++; if (instr !== exp_in[k] || op !== exp_in[k][6:0]) begin n_fail++; $display("FAIL b2b_instr[%0d] got=%h op=%h exp=%h", k, instr, op, exp_in[k]); end
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc[k] + 32'd4) begin n_fail++; $display("FAIL b2b_addr[%0d] got=%0b@%h exp=1@%h", k, imem_req, imem_addr, exp_pc[k] + 32'd4); end
      end
   endtask

   task automatic test_backpressure();
      hold_reset();
      mem_en = 1'b1;
      instr_ready = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k >= 2) begin
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low[%0d] got=%0b exp=0", k, imem_req); end
         end
      end
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head got=%0b/%h exp=1/00000000", instr_valid, instr_pc); end
      instr_ready = 1'b1;
      step();
      n_checks++; if (instr_pc !== 32'h4 || instr !== 32'h17) begin n_fail++; $display("FAIL bp_pop1 got=%h/%h exp=00000004/00000017", instr_pc, instr); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_refetch got=%0b@%h exp=1@00000008", imem_req, imem_addr); end
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin n_fail++; $display("FAIL bp_pop2 got=%0b/%h exp=1/00000008", instr_valid, instr_pc); end
   endtask

   task automatic test_variable_latency();
      hold_reset();
      mem_en = 1'b1;
      lat = 3;
      instr_ready = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_wait[%0d] got=%0b@%h v=%0b exp=1@00000000 v=0", k, imem_req, imem_addr, instr_valid); end
      end
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h13) begin n_fail++; $display("FAIL lat_valid got=%0b/%h/%h exp=1/00000000/00000013", instr_valid, instr_pc, instr); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL lat_next got=%0b@%h exp=1@00000004", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_wait();
      hold_reset();
      instr_ready = 1'b1;
      rst_n = 1'b1;
      step();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_drop got=%0b/%0b exp=0/0", imem_req, instr_valid); end
      man_rv = 1'b1;
      man_rdata = 32'hdead_beef;
      step();
      man_rv = 1'b0;
      n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_discard got=%0b/%0b exp=0/0", instr_valid, imem_req); end
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_newreq got=%0b@%h exp=1@00000100", imem_req, imem_addr); end
      mem_en = 1'b1;
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h113) begin n_fail++; $display("FAIL rw_first got=%0b/%h/%h exp=1/00000100/00000113", instr_valid, instr_pc, instr); end
   endtask

   task automatic test_redirect_rvalid_pop();
      hold_reset();
      mem_en = 1'b1;
      instr_ready = 1'b1;
      rst_n = 1'b1;
      step();
      step();
      step();
      redirect = 1'b1;
      redirect_pc = 32'h203;
      step();
      redirect = 1'b0;
      n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h13 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL rr_flush got=%0b/%h/%h exp=0/00000013/00000000", instr_valid, instr, instr_pc); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rr_idle got=%0b exp=0", imem_req); end
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rr_resume got=%0b@%h exp=1@00000200", imem_req, imem_addr); end
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== 32'h213) begin n_fail++; $display("FAIL rr_first got=%0b/%h/%h exp=1/00000200/00000213", instr_valid, instr_pc, instr); end
   endtask

   task automatic test_async_reset();
      hold_reset();
      mem_en = 1'b1;
      instr_ready = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      mem_en = 1'b0;
      #2;
      n_checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL ar_pre got=%0b/%0b@%h exp=1/1@00000004", imem_req, instr_valid, imem_addr); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL ar_async got=%0b/%0b exp=0/0", imem_req, instr_valid); end
      n_checks++; if (imem_addr !== 32'h0 || instr !== 32'h13) begin n_fail++; $display("FAIL ar_vals got=%h/%h exp=00000000/00000013", imem_addr, instr); end
      step();
      rst_n = 1'b1;
      mem_en = 1'b1;
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_refetch got=%0b@%h exp=1@00000000", imem_req, imem_addr); end
      step();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL ar_first got=%0b/%h exp=1/00000000", instr_valid, instr_pc); end
   endtask

   initial begin
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_variable_latency();
      test_redirect_wait();
      test_redirect_rvalid_pop();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
